// File: rtl/mem_arbiter.sv
// Grants the single main-memory port to the I-cache or D-cache for a whole fill or write.
// Define ARB_RR_EN for a round-robin tie-break; otherwise D wins ties over I.
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int CNT_W       = 4,
  parameter int BLOCK_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_busy,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_busy,
  input  logic              d_wrt,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] d_wdata,
  input  logic              mem_data_valid,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  output logic              i_data_valid,
  output logic              d_data_valid,
  output logic              i_wait,
  output logic              d_wait
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLOCK_WORDS);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             w_req_i, w_req_d, w_issue, w_ret;
`ifdef ARB_RR_EN
  logic             r_last_d;
`endif

  assign w_req_i = i_req | i_busy;
  assign w_req_d = d_req | d_busy | d_wrt;

  // Waits are forced low while rst is held so every output reads 0 in reset.
  assign i_wait  = rst & w_req_i & (r_state != GNT_I);
  assign d_wait  = rst & w_req_d & (r_state != GNT_D);

  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    i_data_valid = 1'b0;
    d_data_valid = 1'b0;
    case (r_state)
      GNT_I: begin
        mem_en       = i_req;
        mem_addr     = i_addr;
        i_data_valid = mem_data_valid;
      end
      GNT_D: begin
        mem_en       = d_req | d_wrt;
        mem_wr       = d_wrt;
        mem_addr     = d_addr;
        mem_wdata    = d_wdata;
        d_data_valid = mem_data_valid;
      end
      default: ;
    endcase
  end

  assign w_issue = mem_en & ~mem_wr;
  assign w_ret   = mem_data_valid & (r_state != IDLE);

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_issue && !w_ret && r_cnt != CNT_MAX)
      w_cnt_next = r_cnt + CNT_W'(1);
    else if (w_ret && !w_issue && r_cnt != '0)
      w_cnt_next = r_cnt - CNT_W'(1);
  end

  // A write-through completes in its granted cycle, so only reads keep GNT_D held.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req_i && w_req_d) begin
`ifdef ARB_RR_EN
          w_next = r_last_d ? GNT_I : GNT_D;
`else
          w_next = GNT_D;
`endif
        end else if (w_req_d) begin
          w_next = GNT_D;
        end else if (w_req_i) begin
          w_next = GNT_I;
        end
      end
      GNT_I: if (!i_busy && !i_req && w_cnt_next == '0) w_next = IDLE;
      GNT_D: if (!d_busy && !d_req && w_cnt_next == '0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_last_d <= 1'b0;
    else if (r_state == IDLE && w_next != IDLE)
      r_last_d <= (w_next == GNT_D);
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: cache fill/write models, a 4-cycle memory
// model and a queue of expected data-valid destinations.
module tb_mem_arbiter;
  localparam int AW = 16;

`ifdef ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_busy, d_req, d_busy, d_wrt, mem_data_valid;
  logic [AW-1:0] i_addr, d_addr, d_wdata;
  logic          mem_en, mem_wr, i_data_valid, d_data_valid, i_wait, d_wait;
  logic [AW-1:0] mem_addr, mem_wdata;

  mem_arbiter #(.ADDR_W(AW), .CNT_W(4), .BLOCK_WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_busy(i_busy), .i_addr(i_addr),
    .d_req(d_req), .d_busy(d_busy), .d_wrt(d_wrt), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_data_valid(mem_data_valid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
    .i_wait(i_wait), .d_wait(d_wait)
  );

  always #5 clk = ~clk;

  int            n_total = 0;
  int            n_bad   = 0;
  bit            i_fill, d_fill, d_wr_pend, model_last_d;
  int            i_issued, i_recv, d_issued, d_recv, i_dv_cnt, d_dv_cnt;
  logic [AW-1:0] i_base, d_base, d_wr_addr, d_wr_data;
  logic [3:0]    vpipe;
  logic [1:0]    exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {26'd0, mem_en, mem_wr, mem_addr, mem_wdata,
            i_data_valid, d_data_valid, i_wait, d_wait};
  endfunction

  // One clock cycle: drive caches and memory after negedge, sample before posedge.
  task automatic tick();
    logic       i_iss, d_iss, w_iss;
    logic [1:0] exp_dv;
    @(negedge clk);
    i_busy         = i_fill;
    d_busy         = d_fill;
    d_wrt          = d_wr_pend;
    i_req          = 1'b0;
    d_req          = 1'b0;
    i_addr         = i_base + AW'(i_issued);
    d_addr         = d_wr_pend ? d_wr_addr : d_base + AW'(d_issued);
    d_wdata        = d_wr_pend ? d_wr_data : '0;
    mem_data_valid = vpipe[0];
    #1;
    i_iss = i_fill && i_issued < 8 && !i_wait;
    d_iss = d_fill && !d_wr_pend && d_issued < 8 && !d_wait;
    w_iss = d_wr_pend && !d_wait;
    i_req = i_iss;
    d_req = d_iss;
    #1;
    check("mem_en", mem_en, i_iss | d_iss | w_iss);
    check("mem_wr", mem_wr, w_iss);
    if (i_iss) begin
      check("i_rd_addr", mem_addr, i_addr);
      exp_q.push_back(2'b10);
      i_issued++;
    end
    if (d_iss) begin
      check("d_rd_addr", mem_addr, d_addr);
      exp_q.push_back(2'b01);
      d_issued++;
    end
    if (w_iss) begin
      check("d_wr_bus", {mem_addr, mem_wdata}, {d_wr_addr, d_wr_data});
      d_wr_pend = 1'b0;
    end
    exp_dv = 2'b00;
    if (mem_data_valid && exp_q.size() != 0) exp_dv = exp_q.pop_front();
    check("dv_route", {i_data_valid, d_data_valid}, exp_dv);
    if (i_data_valid) i_dv_cnt++;
    if (d_data_valid) d_dv_cnt++;
    if (exp_dv == 2'b10) i_recv++;
    if (exp_dv == 2'b01) d_recv++;
    if (i_fill && i_recv == 8) i_fill = 1'b0;
    if (d_fill && d_recv == 8) d_fill = 1'b0;
    vpipe = {mem_en & ~mem_wr, vpipe[3:1]};
  endtask

  task automatic start_i_fill(input logic [AW-1:0] base);
    i_fill = 1'b1; i_issued = 0; i_recv = 0; i_base = base;
  endtask

  task automatic start_d_fill(input logic [AW-1:0] base);
    d_fill = 1'b1; d_issued = 0; d_recv = 0; d_base = base;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    bit done;
    while ((i_fill || d_fill || d_wr_pend || exp_q.size() != 0) && n < bound) begin
      tick();
      n++;
    end
    done = (n < bound);
    check("drain_done", done, 1'b1);
    tick();
    tick();
  endtask

  // Lone write from IDLE: one arbitration cycle, then a single write cycle.
  task automatic do_write(input logic [AW-1:0] addr, input logic [AW-1:0] data);
    d_wr_addr = addr;
    d_wr_data = data;
    d_wr_pend = 1'b1;
    tick();
    check("wr_arb", {d_wait, mem_en}, 2'b10);
    tick();
    check("wr_gnt", {d_wait, mem_en, mem_wr}, 3'b011);
    model_last_d = 1'b1;
  endtask

  task automatic pair();
    bit exp_d_first;
    int n = 0;
    exp_d_first = RR_MODE ? !model_last_d : 1'b1;
    start_i_fill(16'h0500);
    start_d_fill(16'h0600);
    tick();
    check("pair_arb", {i_wait, d_wait}, 2'b11);
    tick();
    check("pair_gnt", {i_wait, d_wait}, {exp_d_first, !exp_d_first});
    while ((exp_d_first ? d_fill : i_fill) && n < 100) begin
      tick();
      n++;
      check("pair_hold", exp_d_first ? i_wait : d_wait, 1'b1);
    end
    drain(100);
    model_last_d = !exp_d_first;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    i_req = 0; i_busy = 0; d_req = 0; d_busy = 0; d_wrt = 0; mem_data_valid = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    i_fill = 0; d_fill = 0; d_wr_pend = 0; model_last_d = 0;
    i_issued = 0; i_recv = 0; d_issued = 0; d_recv = 0; i_dv_cnt = 0; d_dv_cnt = 0;
    i_base = '0; d_base = '0; d_wr_addr = '0; d_wr_data = '0; vpipe = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) tick();
    check("rst_outputs", outs(), 64'd0);
    rst = 1'b1;
    tick();

    // I-fill alone
    i_dv_cnt = 0; d_dv_cnt = 0;
    start_i_fill(16'h0100);
    tick();
    check("i_arb", {i_wait, mem_en}, 2'b10);
    tick();
    check("i_gnt", {i_wait, mem_en, mem_addr}, {1'b0, 1'b1, 16'h0100});
    drain(100);
    check("i_pulses", i_dv_cnt, 8);
    check("d_pulses", d_dv_cnt, 0);
    model_last_d = 1'b0;

    // lone write, then a second write proves the first released after one cycle
    do_write(16'h1234, 16'hBEEF);
    do_write(16'h4321, 16'h0F0F);
    drain(10);

    // simultaneous requests, twice, separated by a lone D write
    pair();
    do_write(16'h0ABC, 16'h1111);
    drain(10);
    pair();

    // write-through raised during an active I-fill
    start_i_fill(16'h0300);
    repeat (3) tick();
    d_wr_addr = 16'h2222;
    d_wr_data = 16'h5555;
    d_wr_pend = 1'b1;
    n = 0;
    while (i_fill && n < 100) begin
      tick();
      n++;
      check("dw_blocked", {d_wait, mem_wr}, 2'b10);
    end
    drain(20);
    model_last_d = 1'b1;

    // reset with three reads outstanding, late valids must be dropped
    start_i_fill(16'h0700);
    n = 0;
    while (i_issued < 3 && n < 20) begin
      tick();
      n++;
    end
    rst = 1'b0;
    #1;
    check("rst_mid", outs(), 64'd0);
    i_fill = 1'b0;
    exp_q.delete();
    i_dv_cnt = 0;
    d_dv_cnt = 0;
    tick();
    rst = 1'b1;
    repeat (6) tick();
    check("late_dv", i_dv_cnt + d_dv_cnt, 0);
    model_last_d = 1'b0;
    do_write(16'h0042, 16'h00FF);
    do_write(16'h0043, 16'h0101);
    drain(10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
